// File: rtl/network_interface_if.sv
// ---------------------------------------------------------------------------
// network_interface_if
//
// Bundles every signal between the network interface and its two neighbours,
// the processing element (PE) and the local port of the mesh router. Only the
// clock and reset are left outside.
//
// Signal groups (names keep the i_/o_ direction as seen by the NI):
//   PE -> NI injection : i_txPayload, i_txDestRow, i_txDestCol, i_txValid, o_txReady
//   NI -> router       : o_routerPacket, o_routerValid, i_routerReady
//   router -> NI       : i_routerPacket, i_routerValid, o_routerReady
//   NI -> PE ejection  : o_rxPayload, o_rxValid, i_rxReady
//   status             : i_clearStatus, o_txPackets, o_rxPackets,
//                        o_rxOverflow, o_rxMisroute
//
// Modports:
//   master : the environment side (PE plus router) that drives the i_* signals
//   slave  : the network interface itself
// ---------------------------------------------------------------------------
interface network_interface_if #(
    parameter int PACKET_WIDTH = 8,
    parameter int COUNT_WIDTH  = 16
);
    localparam int PAYLOAD_WIDTH = PACKET_WIDTH - 4;

    logic [PAYLOAD_WIDTH-1:0] i_txPayload;
    logic [1:0]               i_txDestRow;
    logic [1:0]               i_txDestCol;
    logic                     i_txValid;
    logic                     o_txReady;

    logic [PACKET_WIDTH-1:0]  o_routerPacket;
    logic                     o_routerValid;
    logic                     i_routerReady;

    logic [PACKET_WIDTH-1:0]  i_routerPacket;
    logic                     i_routerValid;
    logic                     o_routerReady;

    logic [PAYLOAD_WIDTH-1:0] o_rxPayload;
    logic                     o_rxValid;
    logic                     i_rxReady;

    logic                     i_clearStatus;
    logic [COUNT_WIDTH-1:0]   o_txPackets;
    logic [COUNT_WIDTH-1:0]   o_rxPackets;
    logic                     o_rxOverflow;
    logic                     o_rxMisroute;

    modport master (
        output i_txPayload, i_txDestRow, i_txDestCol, i_txValid,
        input  o_txReady,
        input  o_routerPacket, o_routerValid,
        output i_routerReady,
        output i_routerPacket, i_routerValid,
        input  o_routerReady,
        input  o_rxPayload, o_rxValid,
        output i_rxReady,
        output i_clearStatus,
        input  o_txPackets, o_rxPackets, o_rxOverflow, o_rxMisroute
    );

    modport slave (
        input  i_txPayload, i_txDestRow, i_txDestCol, i_txValid,
        output o_txReady,
        output o_routerPacket, o_routerValid,
        input  i_routerReady,
        input  i_routerPacket, i_routerValid,
        output o_routerReady,
        output o_rxPayload, o_rxValid,
        input  i_rxReady,
        input  i_clearStatus,
        output o_txPackets, o_rxPackets, o_rxOverflow, o_rxMisroute
    );
endinterface

// File: rtl/network_interface.sv
// ---------------------------------------------------------------------------
// pa_noc : network-wide constants shared by every NoC block.
// ---------------------------------------------------------------------------
package pa_noc;
    localparam int PACKET_WIDTH = 8;
endpackage

// ---------------------------------------------------------------------------
// network_interface
//
// Endpoint between a processing element and the local port of its mesh
// router.
//   - Injection: PE requests are assembled into packets
//     {payload, destRow, destCol} and queued in a TX FIFO. The head is offered
//     to the router only while the router reports room, and it leaves the
//     FIFO on that same edge.
//   - Ejection: router deliveries addressed to this node are queued in an RX
//     FIFO and presented to the PE with valid/ready. Deliveries for another
//     node are dropped (misroute), deliveries into a full FIFO are dropped
//     (overflow).
//   - Statistics: saturating injected/delivered packet counters and sticky
//     error flags, all cleared by i_clearStatus.
//
// Ports:
//   i_clk  : clock, rising edge
//   i_arst : asynchronous active-high reset
//   bus    : network_interface_if.slave carrying all PE/router/status signals
// ---------------------------------------------------------------------------
module network_interface #(
    parameter int                              GRID_WIDTH            = 4,
    parameter logic [$clog2(GRID_WIDTH)-1:0]   NI_ROW                = '0,
    parameter logic [$clog2(GRID_WIDTH)-1:0]   NI_COL                = '0,
    parameter int                              PACKET_WIDTH          = 8,
    parameter int                              TX_FIFO_ADDRESS_WIDTH = 2,
    parameter int                              RX_FIFO_ADDRESS_WIDTH = 2,
    parameter int                              COUNT_WIDTH           = 16
) (
    input  logic               i_clk,
    input  logic               i_arst,
    network_interface_if.slave bus
);
    localparam int COORD_WIDTH   = $clog2(GRID_WIDTH);
    localparam int PAYLOAD_WIDTH = PACKET_WIDTH - 4;
    localparam int TX_AW         = TX_FIFO_ADDRESS_WIDTH;
    localparam int RX_AW         = RX_FIFO_ADDRESS_WIDTH;
    localparam int TX_DEPTH      = 1 << TX_AW;
    localparam int RX_DEPTH      = 1 << RX_AW;

    // The packet format hard-codes two 2-bit coordinate fields.
    generate
        if (GRID_WIDTH != 4 || COORD_WIDTH != 2) begin : g_bad_grid
            $error("network_interface: GRID_WIDTH must be 4");
        end
        if (PACKET_WIDTH != pa_noc::PACKET_WIDTH) begin : g_bad_packet
            $error("network_interface: PACKET_WIDTH must equal pa_noc::PACKET_WIDTH");
        end
    endgenerate

    // ------------------------------------------------------------------
    // TX FIFO state. Occupancy has one extra bit so that its MSB alone
    // means "full" (occupancy can never exceed the depth).
    // ------------------------------------------------------------------
    logic [PACKET_WIDTH-1:0] tx_mem_q [TX_DEPTH];
    logic [PACKET_WIDTH-1:0] tx_mem_d [TX_DEPTH];
    logic [TX_AW-1:0]        tx_wr_q, tx_wr_d;
    logic [TX_AW-1:0]        tx_rd_q, tx_rd_d;
    logic [TX_AW:0]          tx_count_q, tx_count_d;

    logic                    tx_full, tx_empty, tx_push, tx_pop;
    logic [PACKET_WIDTH-1:0] tx_packet;

    assign tx_full   = tx_count_q[TX_AW];
    assign tx_empty  = (tx_count_q == '0);
    assign tx_push   = bus.i_txValid && !tx_full;
    assign tx_pop    = !tx_empty && bus.i_routerReady;
    assign tx_packet = {bus.i_txPayload, bus.i_txDestRow, bus.i_txDestCol};

    assign bus.o_txReady      = !tx_full;
    assign bus.o_routerValid  = tx_pop;
    assign bus.o_routerPacket = tx_pop ? tx_mem_q[tx_rd_q] : '0;

    // ------------------------------------------------------------------
    // RX FIFO state. Only the payload is stored: the address fields of an
    // accepted delivery are known to equal this node's coordinates.
    // ------------------------------------------------------------------
    logic [PAYLOAD_WIDTH-1:0] rx_mem_q [RX_DEPTH];
    logic [PAYLOAD_WIDTH-1:0] rx_mem_d [RX_DEPTH];
    logic [RX_AW-1:0]         rx_wr_q, rx_wr_d;
    logic [RX_AW-1:0]         rx_rd_q, rx_rd_d;
    logic [RX_AW:0]           rx_count_q, rx_count_d;

    logic                     rx_full, rx_empty, rx_pop, rx_route_ok;
    logic                     rx_write, rx_overflow_set, rx_misroute_set;
    logic [RX_AW+1:0]         rx_pending;

    assign rx_full     = rx_count_q[RX_AW];
    assign rx_empty    = (rx_count_q == '0);
    assign rx_pop      = !rx_empty && bus.i_rxReady;
    assign rx_route_ok = (bus.i_routerPacket[3:2] == NI_ROW) &&
                         (bus.i_routerPacket[1:0] == NI_COL);

    // A full FIFO still takes a delivery when the PE is popping the head
    // on the same edge, because the write lands in the slot being freed.
    assign rx_write        = bus.i_routerValid && rx_route_ok && (!rx_full || rx_pop);
    assign rx_overflow_set = bus.i_routerValid && rx_route_ok && rx_full && !rx_pop;
    assign rx_misroute_set = bus.i_routerValid && !rx_route_ok;

    // The router acts on our ready one cycle before its delivery shows up,
    // so a delivery already in flight is counted as occupied and PE pops
    // are deliberately not credited.
    assign rx_pending        = {1'b0, rx_count_q} + (RX_AW+2)'(bus.i_routerValid);
    assign bus.o_routerReady = rx_pending < (RX_AW+2)'(RX_DEPTH);

    assign bus.o_rxValid   = !rx_empty;
    assign bus.o_rxPayload = rx_empty ? '0 : rx_mem_q[rx_rd_q];

    // ------------------------------------------------------------------
    // Statistics state.
    // ------------------------------------------------------------------
    logic [COUNT_WIDTH-1:0] tx_packets_q, tx_packets_d;
    logic [COUNT_WIDTH-1:0] rx_packets_q, rx_packets_d;
    logic                   rx_overflow_q, rx_overflow_d;
    logic                   rx_misroute_q, rx_misroute_d;

    assign bus.o_txPackets  = tx_packets_q;
    assign bus.o_rxPackets  = rx_packets_q;
    assign bus.o_rxOverflow = rx_overflow_q;
    assign bus.o_rxMisroute = rx_misroute_q;

    // TX next state. A push is never allowed while full, so a simultaneous
    // push and pop can never target the slot being read.
    always_comb begin
        tx_mem_d   = tx_mem_q;
        tx_wr_d    = tx_wr_q;
        tx_rd_d    = tx_rd_q;
        tx_count_d = tx_count_q;
        if (tx_push) begin
            tx_mem_d[tx_wr_q] = tx_packet;
            tx_wr_d           = tx_wr_q + 1'b1;
        end
        if (tx_pop) begin
            tx_rd_d = tx_rd_q + 1'b1;
        end
        case ({tx_push, tx_pop})
            2'b10:   tx_count_d = tx_count_q + 1'b1;
            2'b01:   tx_count_d = tx_count_q - 1'b1;
            default: tx_count_d = tx_count_q;
        endcase
    end

    // RX next state. Write and pop together leave occupancy unchanged.
    always_comb begin
        rx_mem_d   = rx_mem_q;
        rx_wr_d    = rx_wr_q;
        rx_rd_d    = rx_rd_q;
        rx_count_d = rx_count_q;
        if (rx_write) begin
            rx_mem_d[rx_wr_q] = bus.i_routerPacket[PACKET_WIDTH-1:4];
            rx_wr_d           = rx_wr_q + 1'b1;
        end
        if (rx_pop) begin
            rx_rd_d = rx_rd_q + 1'b1;
        end
        case ({rx_write, rx_pop})
            2'b10:   rx_count_d = rx_count_q + 1'b1;
            2'b01:   rx_count_d = rx_count_q - 1'b1;
            default: rx_count_d = rx_count_q;
        endcase
    end

    // Statistics next state: clear wins over any same-cycle update, and the
    // counters stop at all-ones.
    always_comb begin
        tx_packets_d  = tx_packets_q;
        rx_packets_d  = rx_packets_q;
        rx_overflow_d = rx_overflow_q;
        rx_misroute_d = rx_misroute_q;
        if (bus.i_clearStatus) begin
            tx_packets_d  = '0;
            rx_packets_d  = '0;
            rx_overflow_d = 1'b0;
            rx_misroute_d = 1'b0;
        end else begin
            if (tx_pop && (tx_packets_q != '1)) begin
                tx_packets_d = tx_packets_q + 1'b1;
            end
            if (rx_pop && (rx_packets_q != '1)) begin
                rx_packets_d = rx_packets_q + 1'b1;
            end
            if (rx_overflow_set) begin
                rx_overflow_d = 1'b1;
            end
            if (rx_misroute_set) begin
                rx_misroute_d = 1'b1;
            end
        end
    end

    // All state registers; reset empties both FIFOs and clears statistics.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            for (int i = 0; i < TX_DEPTH; i++) begin
                tx_mem_q[i] <= '0;
            end
            for (int i = 0; i < RX_DEPTH; i++) begin
                rx_mem_q[i] <= '0;
            end
            tx_wr_q       <= '0;
            tx_rd_q       <= '0;
            tx_count_q    <= '0;
            rx_wr_q       <= '0;
            rx_rd_q       <= '0;
            rx_count_q    <= '0;
            tx_packets_q  <= '0;
            rx_packets_q  <= '0;
            rx_overflow_q <= 1'b0;
            rx_misroute_q <= 1'b0;
        end else begin
            tx_mem_q      <= tx_mem_d;
            rx_mem_q      <= rx_mem_d;
            tx_wr_q       <= tx_wr_d;
            tx_rd_q       <= tx_rd_d;
            tx_count_q    <= tx_count_d;
            rx_wr_q       <= rx_wr_d;
            rx_rd_q       <= rx_rd_d;
            rx_count_q    <= rx_count_d;
            tx_packets_q  <= tx_packets_d;
            rx_packets_q  <= rx_packets_d;
            rx_overflow_q <= rx_overflow_d;
            rx_misroute_q <= rx_misroute_d;
        end
    end
endmodule

// File: tb/tb_network_interface.sv
// ---------------------------------------------------------------------------
// tb_network_interface
//
// Directed bench for network_interface (NI at row 1, column 2, both FIFOs 4
// deep, 8-bit packets). A queue-based reference model tracks the FIFO
// contents, counters and flags; a compare process checks every DUT output
// against it on each falling edge, and the stimulus sequence adds literal
// expectations at the key points.
// ---------------------------------------------------------------------------
module tb_network_interface;
    localparam int DEPTH = 4;

    logic clk;
    logic arst;

    int compared   = 0;
    int mismatched = 0;

    network_interface_if #(.PACKET_WIDTH(8), .COUNT_WIDTH(16)) nif ();

    network_interface #(
        .GRID_WIDTH(4),
        .NI_ROW(2'd1),
        .NI_COL(2'd2),
        .PACKET_WIDTH(8),
        .TX_FIFO_ADDRESS_WIDTH(2),
        .RX_FIFO_ADDRESS_WIDTH(2),
        .COUNT_WIDTH(16)
    ) dut (
        .i_clk(clk),
        .i_arst(arst),
        .bus(nif)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: packets waiting to go out, payloads waiting for the
    // PE, and the status values.
    // ------------------------------------------------------------------
    logic [7:0]  m_txq [$];
    logic [3:0]  m_rxq [$];
    int unsigned m_tx_packets;
    int unsigned m_rx_packets;
    bit          m_overflow;
    bit          m_misroute;

    bit m_tx_pop, m_tx_push, m_rx_pop;

    // Advance the model on each edge using the inputs seen before the edge.
    always @(posedge clk or posedge arst) begin
        if (arst) begin
            m_txq.delete();
            m_rxq.delete();
            m_tx_packets = 0;
            m_rx_packets = 0;
            m_overflow   = 0;
            m_misroute   = 0;
        end else begin
            m_tx_pop  = (m_txq.size() > 0) && nif.i_routerReady;
            m_tx_push = nif.i_txValid && (m_txq.size() < DEPTH);
            m_rx_pop  = (m_rxq.size() > 0) && nif.i_rxReady;
            if (m_tx_pop) void'(m_txq.pop_front());
            if (m_tx_push) m_txq.push_back({nif.i_txPayload, nif.i_txDestRow, nif.i_txDestCol});
            if (m_rx_pop) void'(m_rxq.pop_front());
            if (nif.i_clearStatus) begin
                m_tx_packets = 0;
                m_rx_packets = 0;
                m_overflow   = 0;
                m_misroute   = 0;
            end else begin
                if (m_tx_pop && m_tx_packets < 65535) m_tx_packets++;
                if (m_rx_pop && m_rx_packets < 65535) m_rx_packets++;
            end
            if (nif.i_routerValid) begin
                if (nif.i_routerPacket[3:0] != 4'b0110) begin
                    if (!nif.i_clearStatus) m_misroute = 1;
                end else if (m_rxq.size() >= DEPTH) begin
                    if (!nif.i_clearStatus) m_overflow = 1;
                end else begin
                    m_rxq.push_back(nif.i_routerPacket[7:4]);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h",
                     name, $time, actual, expected);
        end
    endtask

    // Compare every output with the model on each falling edge.
    logic [7:0] e_pkt;
    logic [3:0] e_pay;
    bit         e_rv;
    always @(negedge clk) begin
        e_rv  = (m_txq.size() > 0) && nif.i_routerReady;
        e_pkt = 8'h00;
        if (e_rv) e_pkt = m_txq[0];
        e_pay = 4'h0;
        if (m_rxq.size() > 0) e_pay = m_rxq[0];
        checkOutput("txReady",      32'(nif.o_txReady),      32'(m_txq.size() < DEPTH));
        checkOutput("routerValid",  32'(nif.o_routerValid),  32'(e_rv));
        checkOutput("routerPacket", 32'(nif.o_routerPacket), 32'(e_pkt));
        checkOutput("routerReady",  32'(nif.o_routerReady),
                    32'((m_rxq.size() + 32'(nif.i_routerValid)) < DEPTH));
        checkOutput("rxValid",      32'(nif.o_rxValid),      32'(m_rxq.size() > 0));
        checkOutput("rxPayload",    32'(nif.o_rxPayload),    32'(e_pay));
        checkOutput("txPackets",    32'(nif.o_txPackets),    m_tx_packets);
        checkOutput("rxPackets",    32'(nif.o_rxPackets),    m_rx_packets);
        checkOutput("rxOverflow",   32'(nif.o_rxOverflow),   32'(m_overflow));
        checkOutput("rxMisroute",   32'(nif.o_rxMisroute),   32'(m_misroute));
    end

    // Apply one cycle of inputs just after a rising edge, then return at the
    // following falling edge so literal checks see these inputs applied.
    task automatic applyStimulus(input logic tx_valid, input logic [3:0] payload,
                                 input logic [1:0] row, input logic [1:0] col,
                                 input logic router_ready, input logic router_valid,
                                 input logic [7:0] router_packet, input logic rx_ready,
                                 input logic clear);
        @(posedge clk);
        #1;
        nif.i_txValid      = tx_valid;
        nif.i_txPayload    = payload;
        nif.i_txDestRow    = row;
        nif.i_txDestCol    = col;
        nif.i_routerReady  = router_ready;
        nif.i_routerValid  = router_valid;
        nif.i_routerPacket = router_packet;
        nif.i_rxReady      = rx_ready;
        nif.i_clearStatus  = clear;
        @(negedge clk);
    endtask

    logic [7:0] drain_tx [4] = '{8'h11, 8'h26, 8'h3B, 8'h4C};
    logic [3:0] drain_rx [4] = '{4'h2, 4'h3, 4'h4, 4'h6};

    initial begin
        arst               = 1'b1;
        nif.i_txValid      = 1'b0;
        nif.i_txPayload    = '0;
        nif.i_txDestRow    = '0;
        nif.i_txDestCol    = '0;
        nif.i_routerReady  = 1'b0;
        nif.i_routerValid  = 1'b0;
        nif.i_routerPacket = '0;
        nif.i_rxReady      = 1'b0;
        nif.i_clearStatus  = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        @(posedge clk);
        #1 arst = 1'b0;
        @(negedge clk);
        checkOutput("reset txReady",     32'(nif.o_txReady), 1);
        checkOutput("reset routerReady", 32'(nif.o_routerReady), 1);
        checkOutput("reset rxValid",     32'(nif.o_rxValid), 0);
        checkOutput("reset txPackets",   32'(nif.o_txPackets), 0);

        // Single injection: 0xA to (3,0) becomes packet 0xAC one cycle later.
        $display("[TB] inject");
        applyStimulus(1, 4'hA, 2'd3, 2'd0, 1, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 8'h00, 0, 0);
        checkOutput("inject valid",  32'(nif.o_routerValid), 1);
        checkOutput("inject packet", 32'(nif.o_routerPacket), 32'h00AC);
        applyStimulus(0, 0, 0, 0, 1, 0, 8'h00, 0, 0);
        checkOutput("inject count",  32'(nif.o_txPackets), 1);

        // Backpressure: five pushes with the router blocked, the fifth ignored.
        $display("[TB] tx backpressure");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 4'(i + 1), 2'(i % 4), 2'((i + 1) % 4), 0, 0, 8'h00, 0, 0);
        end
        checkOutput("tx full ready",  32'(nif.o_txReady), 0);
        checkOutput("tx full valid",  32'(nif.o_routerValid), 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0, 8'h00, 0, 0);
            checkOutput("drain valid",  32'(nif.o_routerValid), 1);
            checkOutput("drain packet", 32'(nif.o_routerPacket), 32'(drain_tx[i]));
        end
        applyStimulus(0, 0, 0, 0, 1, 0, 8'h00, 0, 0);
        checkOutput("drain empty", 32'(nif.o_routerValid), 0);
        checkOutput("drain count", 32'(nif.o_txPackets), 5);

        // Single delivery 0x36 addressed to this node.
        $display("[TB] rx path");
        applyStimulus(0, 0, 0, 0, 0, 1, 8'h36, 0, 0);
        checkOutput("rx ready idle", 32'(nif.o_routerReady), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        checkOutput("rx valid",   32'(nif.o_rxValid), 1);
        checkOutput("rx payload", 32'(nif.o_rxPayload), 3);
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        checkOutput("rx popped",  32'(nif.o_rxValid), 0);
        checkOutput("rx count",   32'(nif.o_rxPackets), 1);

        // Fill the RX FIFO, force a fifth delivery, then write while full and popping.
        $display("[TB] rx full");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, {4'(i + 1), 4'h6}, 0, 0);
        end
        checkOutput("rx ready last slot", 32'(nif.o_routerReady), 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 8'h56, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        checkOutput("rx overflow",  32'(nif.o_rxOverflow), 1);
        checkOutput("rx full head", 32'(nif.o_rxPayload), 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 8'h66, 1, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 8'h00, 1, 0);
            checkOutput("rx drain payload", 32'(nif.o_rxPayload), 32'(drain_rx[i]));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        checkOutput("rx drain empty", 32'(nif.o_rxValid), 0);
        checkOutput("rx drain count", 32'(nif.o_rxPackets), 6);

        // Misroute, then clear, then clear racing an increment and a flag set.
        $display("[TB] misroute and clear");
        applyStimulus(0, 0, 0, 0, 0, 1, 8'h30, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        checkOutput("misroute flag",  32'(nif.o_rxMisroute), 1);
        checkOutput("misroute no rx", 32'(nif.o_rxValid), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        checkOutput("clear txPackets", 32'(nif.o_txPackets), 0);
        checkOutput("clear rxPackets", 32'(nif.o_rxPackets), 0);
        checkOutput("clear overflow",  32'(nif.o_rxOverflow), 0);
        checkOutput("clear misroute",  32'(nif.o_rxMisroute), 0);
        applyStimulus(1, 4'h7, 2'd0, 2'd0, 1, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 8'h30, 0, 1);
        checkOutput("race valid", 32'(nif.o_routerValid), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        checkOutput("race txPackets", 32'(nif.o_txPackets), 0);
        checkOutput("race misroute",  32'(nif.o_rxMisroute), 0);

        // Reset with two TX and three RX packets queued.
        $display("[TB] reset mid-operation");
        applyStimulus(1, 4'h9, 2'd3, 2'd3, 1, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 8'h00, 0, 0);
        applyStimulus(1, 4'h1, 2'd2, 2'd1, 0, 0, 8'h00, 0, 0);
        applyStimulus(1, 4'h2, 2'd2, 2'd1, 0, 1, 8'h16, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 8'h26, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 8'h36, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        checkOutput("pre-reset rxValid",   32'(nif.o_rxValid), 1);
        checkOutput("pre-reset txPackets", 32'(nif.o_txPackets), 1);
        #2;
        nif.i_routerReady = 1'b1;
        arst = 1'b1;
        #1;
        checkOutput("mid reset routerValid",  32'(nif.o_routerValid), 0);
        checkOutput("mid reset routerPacket", 32'(nif.o_routerPacket), 0);
        checkOutput("mid reset rxValid",      32'(nif.o_rxValid), 0);
        checkOutput("mid reset rxPayload",    32'(nif.o_rxPayload), 0);
        checkOutput("mid reset txPackets",    32'(nif.o_txPackets), 0);
        @(posedge clk);
        #1;
        arst = 1'b0;
        nif.i_routerReady = 1'b0;
        @(negedge clk);
        checkOutput("post reset txReady",     32'(nif.o_txReady), 1);
        checkOutput("post reset routerReady", 32'(nif.o_routerReady), 1);

        // Self-addressed packet is injected like any other.
        $display("[TB] self-addressed");
        applyStimulus(1, 4'h5, 2'd1, 2'd2, 1, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 8'h00, 0, 0);
        checkOutput("self valid",  32'(nif.o_routerValid), 1);
        checkOutput("self packet", 32'(nif.o_routerPacket), 32'h0056);
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
